// File: rtl/change_logger.sv
// rtl/change_logger.sv - timestamped change logger for an asynchronous single-bit line
module change_logger #(
  parameter int TS_W   = 16,
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     din,
  input  logic                     en,
  input  logic                     clr_ovf,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic                     rd_value,
  output logic [TS_W-1:0]          rd_ts,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic              s1;
  logic              s2;
  logic              prev;
  logic [TS_W-1:0]   ts_cnt;
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [TS_W:0]     mem [DEPTH];
  logic [TS_W:0]     head;

  logic              empty;
  logic              full;
  logic              change;
  logic              push;
  logic              pop;
  logic              wr_en;
  logic              drop;

  always_comb begin
    empty  = (wr_ptr == rd_ptr);
    full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    change = (s2 != prev);
    push   = change & en;
    pop    = ~empty & rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    wr_en  = push & (~full | pop);
    drop   = push & full & ~pop;
  end

  always_comb begin
    head     = mem[rd_ptr[AW-1:0]];
    rd_valid = ~empty;
    rd_value = empty ? 1'b0 : head[0];
    rd_ts    = empty ? '0 : head[TS_W:1];
    level    = wr_ptr - rd_ptr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      prev   <= 1'b0;
      ts_cnt <= '0;
    end else begin
      s1     <= din;
      s2     <= s1;
      prev   <= s2;
      ts_cnt <= ts_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {ts_cnt, s2};
  end

  // Clear has priority over a drop landing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != {DROP_W{1'b1}}) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_change_logger.sv
// tb/tb_change_logger.sv - self-checking bench for change_logger
module tb_change_logger;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic din = 1'b0, en = 1'b1, clr_ovf = 1'b0, rd_ready = 1'b0;

  logic a_valid, a_value, a_ovf;
  logic [15:0] a_ts;
  logic [3:0]  a_level;
  logic [7:0]  a_drop;
  logic b_valid, b_value, b_ovf;
  logic [3:0]  b_ts;
  logic [3:0]  b_level;
  logic [1:0]  b_drop;

  change_logger #(.TS_W(16), .DEPTH(DEPTH), .DROP_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en), .clr_ovf(clr_ovf), .rd_ready(rd_ready),
    .rd_valid(a_valid), .rd_value(a_value), .rd_ts(a_ts), .level(a_level),
    .overflow(a_ovf), .drop_cnt(a_drop));

  change_logger #(.TS_W(4), .DEPTH(DEPTH), .DROP_W(2)) u_wrap (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en), .clr_ovf(clr_ovf), .rd_ready(rd_ready),
    .rd_valid(b_valid), .rd_value(b_value), .rd_ts(b_ts), .level(b_level),
    .overflow(b_ovf), .drop_cnt(b_drop));

  int checks = 0;
  int errors = 0;

  typedef struct { int ts; bit val; } rec_t;
  int   cyc;
  bit   samp[$];
  rec_t q[$];
  bit   m_ovf;
  int   m_drop;

  typedef struct { int n_chg; bit clr; int n_pop; int exp_level; bit exp_ovf; int exp_drop; } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit smp(input int k);
    return (k < 1) ? 1'b0 : samp[k-1];
  endfunction

  task automatic model_reset();
    cyc = 0;
    samp.delete();
    q.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  task automatic check_all();
    rec_t h;
    h = '{ts: 0, val: 1'b0};
    if (q.size() > 0) h = q[0];
    chk("a_valid", a_valid, q.size() > 0);
    chk("a_level", a_level, q.size());
    chk("a_value", a_value, h.val);
    chk("a_ts",    a_ts,    h.ts % 65536);
    chk("a_ovf",   a_ovf,   m_ovf);
    chk("a_drop",  a_drop,  (m_drop > 255) ? 255 : m_drop);
    chk("b_valid", b_valid, q.size() > 0);
    chk("b_level", b_level, q.size());
    chk("b_value", b_value, h.val);
    chk("b_ts",    b_ts,    h.ts % 16);
    chk("b_ovf",   b_ovf,   m_ovf);
    chk("b_drop",  b_drop,  (m_drop > 3) ? 3 : m_drop);
  endtask

  // Edge n sees din sampled at edge n; a change seen two edges ago versus three edges ago
  // is logged at edge n with the timestamp of the cycle before it.
  task automatic step();
    int n;
    bit pop;
    bit push;
    bit dropped;
    rec_t r;
    n = cyc + 1;
    samp.push_back(din);
    push    = (smp(n-2) != smp(n-3)) && en;
    pop     = (q.size() > 0) && rd_ready;
    dropped = 1'b0;
    if (pop) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEPTH) begin
        r.ts  = n - 1;
        r.val = smp(n-2);
        q.push_back(r);
      end else begin
        dropped = 1'b1;
      end
    end
    if (clr_ovf) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end else if (dropped) begin
      m_ovf = 1'b1;
      m_drop++;
    end
    @(posedge clk);
    #1;
    cyc = n;
    check_all();
  endtask

  task automatic hard_reset(input bit d);
    rst_n    = 1'b0;
    din      = d;
    en       = 1'b1;
    clr_ovf  = 1'b0;
    rd_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #4 rst_n = 1'b1;
    model_reset();
    check_all();
  endtask

  task automatic toggles(input int n);
    for (int i = 0; i < n; i++) begin
      din = ~din;
      step();
      step();
    end
    repeat (3) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ts;
    int rprob;

    tbl[0] = '{n_chg: 3, clr: 1'b0, n_pop: 0, exp_level: 3, exp_ovf: 1'b0, exp_drop: 0};
    tbl[1] = '{n_chg: 7, clr: 1'b0, n_pop: 0, exp_level: 8, exp_ovf: 1'b1, exp_drop: 2};
    tbl[2] = '{n_chg: 0, clr: 1'b1, n_pop: 0, exp_level: 8, exp_ovf: 1'b0, exp_drop: 0};
    tbl[3] = '{n_chg: 0, clr: 1'b0, n_pop: 5, exp_level: 3, exp_ovf: 1'b0, exp_drop: 0};
    tbl[4] = '{n_chg: 2, clr: 1'b0, n_pop: 0, exp_level: 5, exp_ovf: 1'b0, exp_drop: 0};
    tbl[5] = '{n_chg: 0, clr: 1'b0, n_pop: 5, exp_level: 0, exp_ovf: 1'b0, exp_drop: 0};

    // Reset release with din high logs exactly one rising change at ts 2.
    hard_reset(1'b1);
    step();
    step();
    chk("rel_no_early_valid", a_valid, 0);
    step();
    chk("rel_level", a_level, 1);
    chk("rel_value", a_value, 1);
    chk("rel_ts", a_ts, 2);
    chk("rel_ovf", a_ovf, 0);
    repeat (3) step();
    chk("rel_level_hold", a_level, 1);

    // Toggle sequence 1,1,0,1 at 10-cycle spacing.
    hard_reset(1'b0);
    repeat (9) step();
    din = 1'b1; repeat (10) step();
    din = 1'b1; repeat (10) step();
    din = 1'b0; repeat (10) step();
    din = 1'b1; repeat (10) step();
    chk("tog_level", a_level, 3);
    chk("tog_v0", a_value, 1);
    chk("tog_t0", a_ts, 11);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    chk("tog_v1", a_value, 0);
    chk("tog_t1", a_ts, 31);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    chk("tog_v2", a_value, 1);
    chk("tog_t2", a_ts, 41);

    // Table-driven overflow / clear / drain phases.
    hard_reset(1'b0);
    for (int i = 0; i < 6; i++) begin
      rd_ready = 1'b0;
      if (tbl[i].n_chg > 0) toggles(tbl[i].n_chg);
      if (tbl[i].clr) begin
        clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
      end
      for (int p = 0; p < tbl[i].n_pop; p++) begin
        rd_ready = 1'b1; step();
      end
      rd_ready = 1'b0;
      chk($sformatf("tbl%0d_level", i), a_level, tbl[i].exp_level);
      chk($sformatf("tbl%0d_ovf", i), a_ovf, tbl[i].exp_ovf);
      chk($sformatf("tbl%0d_drop", i), a_drop, tbl[i].exp_drop);
    end

    // Push and pop on the same edge while full.
    hard_reset(1'b0);
    toggles(8);
    chk("full_level", a_level, 8);
    din = ~din;
    exp_ts = cyc + 2;
    step();
    step();
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    chk("pp_level", a_level, 8);
    chk("pp_ovf", a_ovf, 0);
    chk("pp_drop", a_drop, 0);
    repeat (7) begin
      rd_ready = 1'b1; step();
    end
    rd_ready = 1'b0;
    chk("pp_head_level", a_level, 1);
    chk("pp_head_ts", a_ts, exp_ts);
    chk("pp_head_value", a_value, din);

    // en gating, then a change logged right after the 4-bit counter wraps.
    hard_reset(1'b0);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din = ~din;
      repeat (3) step();
    end
    chk("en0_level", a_level, 0);
    en = 1'b1;
    repeat (5) step();
    chk("en1_valid", a_valid, 0);
    chk("en1_level", b_level, 0);
    while (!(cyc > 16 && ((cyc + 1) % 16) == 0)) step();
    din = ~din;
    exp_ts = cyc + 2;
    repeat (3) step();
    chk("wrap_b_ts", b_ts, 1);
    chk("wrap_a_ts", a_ts, exp_ts);
    chk("wrap_level", b_level, 1);

    // Asynchronous reset with records queued.
    hard_reset(1'b0);
    toggles(5);
    chk("mid_level_pre", a_level, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_valid", a_valid, 0);
    chk("mid_level", a_level, 0);
    chk("mid_ts", a_ts, 0);
    chk("mid_b_level", b_level, 0);
    #2 rst_n = 1'b1;
    model_reset();
    repeat (4) step();
    chk("mid_resume_level", a_level, 1);
    chk("mid_resume_value", a_value, 1);

    // Randomized traffic against the reference model.
    hard_reset(1'b0);
    for (int blk = 0; blk < 10; blk++) begin
      case ($urandom_range(0, 3))
        0: rprob = 0;
        1: rprob = 30;
        2: rprob = 70;
        default: rprob = 100;
      endcase
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 99) < 25) din = ~din;
        en       = ($urandom_range(0, 9) != 0);
        clr_ovf  = ($urandom_range(0, 49) == 0);
        rd_ready = ($urandom_range(0, 99) < rprob);
        step();
      end
    end
    clr_ovf  = 1'b0;
    rd_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/change_logger.md
# change_logger

Synthesizable observer for a single-bit stimulus line. It synchronizes an asynchronous input, detects every value change, and timestamps each change with a free-running cycle counter. Each change is queued as a {timestamp, new value} record in a small show-ahead FIFO that a consumer drains over a valid/ready handshake. It is the receiving end of the bit-sequence stimulus drivers in the design, and it replaces simulation-only `$display` monitors with hardware that can be checked on silicon.

## Interface
- TS_W, 16, timestamp/counter width
- DEPTH, 8, FIFO entries; power of two, ≥2
- DROP_W, 8, width of saturating drop counter
- clk  input  1  single clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- din  input  1  observed line, asynchronous to clk
- en  input  1  logging enable, synchronous
- clr_ovf  input  1  synchronous clear of overflow and drop_cnt
- rd_ready  input  1  consumer accepts head record
- rd_valid  output  1  FIFO non-empty; head record valid
- rd_value  output  1  new din value of head record
- rd_ts  output  TS_W  timestamp of head record
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: a change was dropped
- drop_cnt  output  DROP_W  dropped changes, saturating

## Operation
- Two-flop synchronizer: din -> s1 -> s2. prev holds the last accepted s2 value.
- Change is detected when s2 != prev. prev <= s2 every cycle, whether or not en is high, so re-enabling never produces a stale event.
- Push occurs on a detected change with en=1. The record is {ts_cnt, s2}, where ts_cnt is its value in the detect cycle.
- ts_cnt is free-running: +1 every clock and wraps from 2^TS_W-1 to 0. Wrap has no other effect.
- The FIFO is circular with wr_ptr/rd_ptr of width $clog2(DEPTH)+1 (MSB used for full/empty). Pointers wrap at DEPTH.
- Pop occurs when rd_valid & rd_ready.
- Read is show-ahead: rd_value/rd_ts are combinational from mem[rd_ptr]. They are 0 when empty.
- Full with push and no pop: the record is dropped, overflow <= 1, and drop_cnt increments, saturating at 2^DROP_W-1.
- Full with push and pop in the same cycle: both are accepted, no drop, level unchanged.
- Empty with push and pop in the same cycle: pop is impossible because rd_valid=0, so only the push takes effect.
- clr_ovf in the same cycle as a drop: the clear wins, giving overflow=0 and drop_cnt=0.
- Reset values:
  - s1, s2, prev, ts_cnt, and both pointers are 0.
  - rd_valid, rd_value, rd_ts, level, overflow, and drop_cnt are 0.
  - FIFO memory need not reset.
- Because prev resets to 0, din=1 at reset release is logged as one rising change.
- Reset asserted mid-operation empties the FIFO immediately. All queued records are lost.

## Timing
- din transition settles before edge E0. s1 captures at E0, s2 at E1. Detection is combinational in the E1–E2 cycle, and the push happens at E2.
- rd_valid rises after E2, which is 2 cycles of input latency plus 1 cycle of FIFO latency.
- Logged timestamp = ts_cnt during E1–E2 = number of clk edges from reset release through E1.
- A pop at edge E advances rd_ptr. The next record appears on rd_* after E, with no bubble.
- level updates on the same edge as the push or pop.
- Pulses on din shorter than one clk period may be missed. This is acceptable and not an error.
- Throughput: one record per cycle in and one per cycle out.

## Test plan
- **Reset release with din=1, en=1:**
  - Required: exactly one record with rd_value=1 and rd_ts=2.
  - Required: level=1, overflow=0.
- **Toggle sequence:**
  - Stimulus: din=0 at reset. Drive din 1,1,0,1 at 10-cycle spacing starting cycle 10.
  - Required: 3 records with values 1,0,1 and timestamps spaced 20 and 10 apart.
  - Required: rd_ready held low leaves level=3.
- **Overflow with DEPTH=8 and rd_ready=0:**
  - Stimulus: 10 changes.
  - Required: level=8, overflow=1, drop_cnt=2, head record = first change.
  - Stimulus: assert clr_ovf.
  - Required: overflow=0, drop_cnt=0, FIFO untouched.
- **Simultaneous push/pop while full:**
  - Stimulus: rd_ready=1 in the same cycle a 9th change is detected.
  - Required: no drop, level stays 8, and the new record reaches the head after 8 pops.
- **en gating and timestamp wrap with TS_W=4:**
  - Stimulus: toggle din with en=0, then raise en.
  - Required: no records during en=0 and no spurious record on enable.
  - Stimulus: let the counter pass 15.
  - Required: a change detected at ts_cnt=1 after wrap logs rd_ts=1.
- **Mid-operation reset:**
  - Stimulus: with 5 queued records, pulse rst_n low asynchronously between edges.
  - Required: rd_valid=0, level=0, rd_ts=0 immediately.
  - Required: normal logging resumes after release.
